// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and defaults for the parametrised sequence detector
package seq_det_pkg;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } det_state_t;

    localparam int         DEF_PAT_LEN = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int         DEF_CNT_W   = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // clear beats increment; increments stop at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - Moore serial pattern detector with loadable pattern and match counter
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               q_in,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               clr_cnt,
    output logic               q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    localparam int             FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] pat;
    logic [FW-1:0]      fill;
    det_state_t         state;

    logic [PAT_LEN-1:0] hist_nxt;
    logic [FW-1:0]      fill_nxt;
    logic               hit;

    // a match is judged on the history as it will be after this sample
    always_comb begin
        hist_nxt = {hist[PAT_LEN-2:0], q_in};
        fill_nxt = (fill == FULL) ? FULL : fill + 1'b1;
        hit      = en && !pat_load && (hist_nxt == pat) && (fill_nxt == FULL);
    end

    // history, fill level, pattern register, state and match pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist  <= '0;
            fill  <= '0;
            pat   <= PATTERN;
            state <= S_FILL;
            q     <= 1'b0;
        end else if (pat_load) begin
            // a new pattern invalidates whatever history was collected
            pat   <= pat_in;
            hist  <= '0;
            fill  <= '0;
            state <= S_FILL;
            q     <= 1'b0;
        end else if (en) begin
            q <= hit;
            if (hit && !OVERLAP) begin
                hist  <= '0;
                fill  <= '0;
                state <= S_FILL;
            end else begin
                hist  <= hist_nxt;
                fill  <= fill_nxt;
                state <= (fill_nxt == FULL) ? S_ARMED : S_FILL;
            end
        end else begin
            q <= 1'b0;
        end
    end

    assign armed = (state == S_ARMED);

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (hit),
        .clr  (clr_cnt),
        .count(match_cnt)
    );

endmodule

// File: tb/tb_seq_det_param.sv
// tb/tb_seq_det_param.sv - directed table-driven bench for seq_det_param
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       q_in = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'h0;
    logic       clr_cnt = 1'b0;

    logic       q_ov, q_no, q_sat;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_sat;
    logic       arm_ov, arm_no, arm_sat;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in), .pat_load(pat_load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .q(q_ov), .match_cnt(cnt_ov), .armed(arm_ov));

    seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in), .pat_load(pat_load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .q(q_no), .match_cnt(cnt_no), .armed(arm_no));

    seq_det_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .q_in(q_in), .pat_load(pat_load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .q(q_sat), .match_cnt(cnt_sat), .armed(arm_sat));

    typedef struct {
        logic       en;
        logic       d;
        logic       ld;
        logic [3:0] pin;
        logic       clr;
        logic       q_ov;
        logic [7:0] c_ov;
        logic       a_ov;
        logic       q_no;
        logic [7:0] c_no;
        logic       a_no;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic d, input logic ld, input logic [3:0] pin,
                       input logic clr, input logic qo, input logic [7:0] co, input logic ao,
                       input logic qn, input logic [7:0] cn, input logic an);
        vec_t v;
        v.en = e; v.d = d; v.ld = ld; v.pin = pin; v.clr = clr;
        v.q_ov = qo; v.c_ov = co; v.a_ov = ao;
        v.q_no = qn; v.c_no = cn; v.a_no = an;
        tbl.push_back(v);
    endtask

    // apply one set of inputs for one clock, leave time just after the edge
    task automatic step(input logic e, input logic d, input logic ld, input logic [3:0] pin,
                        input logic clr);
        @(negedge clk);
        en = e; q_in = d; pat_load = ld; pat_in = pin; clr_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 1'b0; q_in = 1'b0; pat_load = 1'b0; clr_cnt = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // stream 1011 0 11 1 0 11, then gap, reload to 0110, match, mismatch, clear
        add(1,1,0,4'h0,0, 0,8'd0,0, 0,8'd0,0);
        add(1,0,0,4'h0,0, 0,8'd0,0, 0,8'd0,0);
        add(1,1,0,4'h0,0, 0,8'd0,0, 0,8'd0,0);
        add(1,1,0,4'h0,0, 1,8'd1,1, 1,8'd1,0);
        add(1,0,0,4'h0,0, 0,8'd1,1, 0,8'd1,0);
        add(1,1,0,4'h0,0, 0,8'd1,1, 0,8'd1,0);
        add(1,1,0,4'h0,0, 1,8'd2,1, 0,8'd1,0);
        add(1,1,0,4'h0,0, 0,8'd2,1, 0,8'd1,1);
        add(1,0,0,4'h0,0, 0,8'd2,1, 0,8'd1,1);
        add(1,1,0,4'h0,0, 0,8'd2,1, 0,8'd1,1);
        add(1,1,0,4'h0,0, 1,8'd3,1, 1,8'd2,0);
        add(0,1,0,4'h0,0, 0,8'd3,1, 0,8'd2,0);
        add(1,1,1,4'h6,0, 0,8'd3,0, 0,8'd2,0);
        add(1,0,0,4'h0,0, 0,8'd3,0, 0,8'd2,0);
        add(1,1,0,4'h0,0, 0,8'd3,0, 0,8'd2,0);
        add(1,1,0,4'h0,0, 0,8'd3,0, 0,8'd2,0);
        add(1,0,0,4'h0,0, 1,8'd4,1, 1,8'd3,0);
        add(1,1,0,4'h0,0, 0,8'd4,1, 0,8'd3,0);
        add(1,0,0,4'h0,0, 0,8'd4,1, 0,8'd3,0);
        add(1,1,0,4'h0,0, 0,8'd4,1, 0,8'd3,0);
        add(1,1,0,4'h0,0, 0,8'd4,1, 0,8'd3,1);
        add(0,0,0,4'h0,1, 0,8'd0,1, 0,8'd0,1);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q_ov",    32'(q_ov),    32'd0);
        chk("rst_cnt_ov",  32'(cnt_ov),  32'd0);
        chk("rst_arm_ov",  32'(arm_ov),  32'd0);
        chk("rst_q_no",    32'(q_no),    32'd0);
        chk("rst_cnt_no",  32'(cnt_no),  32'd0);
        chk("rst_cnt_sat", 32'(cnt_sat), 32'd0);
        chk("rst_arm_sat", 32'(arm_sat), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].d, tbl[i].ld, tbl[i].pin, tbl[i].clr);
            chk($sformatf("v%0d_q_ov", i),   32'(q_ov),   32'(tbl[i].q_ov));
            chk($sformatf("v%0d_cnt_ov", i), 32'(cnt_ov), 32'(tbl[i].c_ov));
            chk($sformatf("v%0d_arm_ov", i), 32'(arm_ov), 32'(tbl[i].a_ov));
            chk($sformatf("v%0d_q_no", i),   32'(q_no),   32'(tbl[i].q_no));
            chk($sformatf("v%0d_cnt_no", i), 32'(cnt_no), 32'(tbl[i].c_no));
            chk($sformatf("v%0d_arm_no", i), 32'(arm_no), 32'(tbl[i].a_no));
        end

        // reset restores the default pattern; then async reset mid-sequence
        do_reset();
        step(1, 1, 0, 4'h0, 0);
        step(1, 0, 0, 4'h0, 0);
        step(1, 1, 0, 4'h0, 0);
        step(1, 1, 0, 4'h0, 0);
        chk("rpat_q", 32'(q_ov), 32'd1);
        chk("rpat_cnt", 32'(cnt_ov), 32'd1);
        step(1, 1, 0, 4'h0, 0);
        step(1, 0, 0, 4'h0, 0);
        step(1, 1, 0, 4'h0, 0);
        rst = 1'b0;
        #2;
        chk("async_cnt", 32'(cnt_ov), 32'd0);
        chk("async_arm", 32'(arm_ov), 32'd0);
        chk("async_q", 32'(q_ov), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(1, 1, 0, 4'h0, 0);
        chk("post_rst_q", 32'(q_ov), 32'd0);
        chk("post_rst_arm", 32'(arm_ov), 32'd0);
        chk("post_rst_cnt", 32'(cnt_ov), 32'd0);
        step(1, 0, 0, 4'h0, 0);
        chk("post_rst_q2", 32'(q_ov), 32'd0);
        step(1, 1, 0, 4'h0, 0);
        chk("post_rst_q3", 32'(q_ov), 32'd0);
        step(1, 1, 0, 4'h0, 0);
        chk("post_rst_q4", 32'(q_ov), 32'd1);
        chk("post_rst_arm4", 32'(arm_ov), 32'd1);

        // enable gaps hold the history
        do_reset();
        step(1, 1, 0, 4'h0, 0);
        step(1, 0, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 4'h0, 0);
            chk($sformatf("gap%0d_q", i), 32'(q_ov), 32'd0);
        end
        step(1, 1, 0, 4'h0, 0);
        chk("gap_q3", 32'(q_ov), 32'd0);
        step(1, 1, 0, 4'h0, 0);
        chk("gap_q4", 32'(q_ov), 32'd1);
        chk("gap_cnt", 32'(cnt_ov), 32'd1);
        step(1, 0, 0, 4'h0, 0);
        chk("gap_q_one_cycle", 32'(q_ov), 32'd0);

        // 2-bit counter saturates at 3; clear beats a coincident match
        do_reset();
        step(1, 1, 0, 4'h0, 0);
        step(1, 0, 0, 4'h0, 0);
        step(1, 1, 0, 4'h0, 0);
        step(1, 1, 0, 4'h0, 0);
        chk("sat_m1", 32'(cnt_sat), 32'd1);
        for (int m = 2; m <= 5; m++) begin
            step(1, 0, 0, 4'h0, 0);
            step(1, 1, 0, 4'h0, 0);
            step(1, 1, 0, 4'h0, 0);
            chk($sformatf("sat_q_m%0d", m), 32'(q_sat), 32'd1);
            chk($sformatf("sat_cnt_m%0d", m), 32'(cnt_sat), (m < 3) ? m : 3);
        end
        step(1, 0, 0, 4'h0, 0);
        step(1, 1, 0, 4'h0, 0);
        step(1, 1, 0, 4'h0, 1);
        chk("clr_match_cnt", 32'(cnt_sat), 32'd0);
        chk("clr_match_q", 32'(q_sat), 32'd1);
        chk("clr_match_cnt_ov", 32'(cnt_ov), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised Moore sequence detector, successor to the fixed-pattern serial detector `sd`. It samples one serial bit per enabled clock and compares a PAT_LEN-bit history against a runtime-loadable pattern. It raises a registered one-cycle match pulse and keeps a saturating match count. Overlapping or non-overlapping detection is selected by parameter. It sits on serial input paths (frame-sync / marker detection), fed directly from a synchronised `q_in`.

## Interface
- PAT_LEN, 4: pattern length in bits, 2..16
- PATTERN, 4'b1011: reset value of the pattern register; bit PAT_LEN-1 is the first bit received
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = history discarded after each match
- CNT_W, 8: match counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- en  in  1  sample enable; `q_in` is consumed only when en=1
- q_in  in  1  serial data bit
- pat_load  in  1  load `pat_in` into the pattern register
- pat_in  in  PAT_LEN  new pattern
- clr_cnt  in  1  synchronous clear of `match_cnt`
- q  out  1  match pulse, registered (Moore)
- match_cnt  out  CNT_W  saturating count of matches
- armed  out  1  history holds PAT_LEN valid bits (state S_ARMED)

## Operation
- Registers: `hist[PAT_LEN-1:0]`, `fill` (0..PAT_LEN), `pat`, `state`, `q`, `match_cnt`.
- States:
  - S_FILL: fill < PAT_LEN.
  - S_ARMED: fill == PAT_LEN.
  - S_FILL→S_ARMED when fill reaches PAT_LEN.
  - S_ARMED→S_FILL on a match with OVERLAP=0, on pat_load, or on reset.
- Enabled sample (en=1, pat_load=0):
  - hist ← {hist[PAT_LEN-2:0], q_in}.
  - fill ← min(fill+1, PAT_LEN).
  - A match occurs when the new hist == pat and the new fill == PAT_LEN. Then q←1 and match_cnt increments, saturating at all-ones.
  - Otherwise q←0.
- OVERLAP=0 and match: fill←0, hist←0 in that cycle. The next match needs PAT_LEN fresh bits.
- en=0: hist, fill and state hold; q←0; no count change.
- pat_load=1 has priority over sampling:
  - pat←pat_in; fill←0; hist←0; q←0.
  - `q_in` is not sampled in that cycle.
- clr_cnt=1: match_cnt←0. This wins over a simultaneous match; the count stays 0. q still pulses.
- Reset (rst=0, asynchronous):
  - q=0, match_cnt=0, armed=0, hist=0, fill=0.
  - pat=PATTERN, state=S_FILL.

## Timing
- Latency: q is high for exactly the one cycle after the rising edge that samples the last pattern bit.
- q never stays high more than one cycle per match. Back-to-back pulses are possible only with OVERLAP=1 and a self-overlapping pattern (e.g. 1111).
- match_cnt updates on the same edge as q.
- armed is registered and asserts on the edge where fill becomes PAT_LEN.
- Reset asserted mid-sequence clears everything immediately. After release, PAT_LEN new enabled bits are needed before any match.
- A pat_load mid-sequence discards the partial history. Matching uses the new pattern from the next enabled edge.

## Structure
- Package `seq_det_pkg`: state enum (S_FILL, S_ARMED) and the default pattern and width constants.
- Sub-module `sat_counter` (parameter W; inputs inc and clr, clr wins; output count) implements match_cnt.
- Everything else lives in one always_ff block plus combinational match compare.

## Test plan
- Overlap detection: PAT_LEN=4, PATTERN=1011, OVERLAP=1; stream 1,0,1,1,0,1,1 with en=1 → q pulses after the 4th and 7th bits; match_cnt=2.
- Non-overlap: same pattern, OVERLAP=0:
  - Stream 1,0,1,1,0,1,1 → one pulse; match_cnt=1.
  - Continue with 1,0,1,1 → second pulse; match_cnt=2.
- Reset mid-operation: feed 1,0,1; assert rst=0 for 1 cycle; release; feed 1 → no pulse; q=0, armed=0, match_cnt=0.
- Runtime pattern: pat_load with pat_in=0110, then stream 0,1,1,0 → pulse after the 4th bit. Stream 1,0,1,1 → no pulse.
- Enable gaps: feed 1,0; hold en=0 for 3 cycles with q_in=0; then feed 1,1 → single pulse; q=0 throughout the en=0 cycles.
- Saturation and clear:
  - CNT_W=2; 5 matches → match_cnt=3.
  - clr_cnt coincident with a 6th match → match_cnt=0 and q=1 for that cycle.
